// File: rtl/lb_addr_gen.sv
// Line-buffer write-address generator: beats -> addr/bank/line markers, done after drain.
// Optional word-pair mode (two beats per address) enabled by LB_ADDR_PAIR_EN.
module lb_addr_gen #(
  parameter int LC_BITS       = 20,
  parameter int ADDR_W        = 10,
  parameter int ROW_W         = 8,
  parameter int NUM_BANKS     = 2,
  parameter int EXTRA_LATENCY = 5
) (
  input  logic                         fclk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [LC_BITS-1:0]           layer_code,
  input  logic                         valid,
  output logic [ADDR_W-1:0]            addr,
  output logic [$clog2(NUM_BANKS)-1:0] bank,
  output logic                         sel,
  output logic                         wr_en,
  output logic                         line_end,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int BW = $clog2(NUM_BANKS);
  localparam int DW = (EXTRA_LATENCY < 2) ? 1 : $clog2(EXTRA_LATENCY);
  localparam logic [DW-1:0] DRN_LAST =
    DW'((EXTRA_LATENCY > 0) ? EXTRA_LATENCY - 1 : 0);
  localparam logic [BW-1:0] BANK_LAST = BW'(NUM_BANKS - 1);

`ifdef LB_ADDR_PAIR_EN
  localparam bit PAIR = 1'b1;
`else
  localparam bit PAIR = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] len_q, len_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DW-1:0]     drn_q, drn_d;
  logic              half_q, half_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BW-1:0]     bank_q, bank_d;
  logic              sel_q, sel_d;
  logic              wr_en_q, wr_en_d;
  logic              line_end_q, line_end_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] len_in;
  logic [ROW_W-1:0]  rows_in;
  logic              adv;
  logic              unused_lc;

  assign len_in    = layer_code[LC_BITS-9 -: ADDR_W];
  assign rows_in   = layer_code[ROW_W-1:0];
  assign unused_lc = ^layer_code;
  // in pair mode only the second half-beat moves the column
  assign adv       = !PAIR || half_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rows_d     = rows_q;
    col_d      = col_q;
    row_d      = row_q;
    bcnt_d     = bcnt_q;
    drn_d      = drn_q;
    half_d     = half_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    sel_d      = sel_q;
    wr_en_d    = 1'b0;
    line_end_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_in != '0 && rows_in != '0) begin
            len_d   = len_in;
            rows_d  = rows_in;
            col_d   = '0;
            row_d   = '0;
            half_d  = 1'b0;
            drn_d   = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (valid) begin
          wr_en_d = 1'b1;
          addr_d  = col_q;
          bank_d  = bcnt_q;
          sel_d   = half_q;
          half_d  = PAIR && !half_q;
          if (adv) begin
            if (col_q == len_q - ADDR_W'(1)) begin
              col_d      = '0;
              line_end_d = 1'b1;
              bcnt_d     = (bcnt_q == BANK_LAST) ? '0 : bcnt_q + BW'(1);
              if (row_q == rows_q - ROW_W'(1)) begin
                row_d = '0;
                drn_d = '0;
                if (EXTRA_LATENCY == 0) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
                end else begin
                  state_d = DRAIN;
                end
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end else begin
              col_d = col_q + ADDR_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (drn_q == DRN_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge fclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rows_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      bcnt_q     <= '0;
      drn_q      <= '0;
      half_q     <= 1'b0;
      addr_q     <= '0;
      bank_q     <= '0;
      sel_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      line_end_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rows_q     <= rows_d;
      col_q      <= col_d;
      row_q      <= row_d;
      bcnt_q     <= bcnt_d;
      drn_q      <= drn_d;
      half_q     <= half_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      sel_q      <= sel_d;
      wr_en_q    <= wr_en_d;
      line_end_q <= line_end_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign addr     = addr_q;
  assign bank     = bank_q;
  assign sel      = sel_q;
  assign wr_en    = wr_en_q;
  assign line_end = line_end_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_lb_addr_gen.sv
// Directed bench for lb_addr_gen: three instances (2 banks, 3 banks, zero drain).
// Pair-mode expectations are selected with LB_ADDR_PAIR_EN.
module tb_lb_addr_gen;

  localparam int LC = 26;
  localparam int AW = 10;

  logic          fclk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [LC-1:0] layer_code;
  logic          valid;

  logic [AW-1:0] addr2, addr3, addrp;
  logic [0:0]    bank2, bankp;
  logic [1:0]    bank3;
  logic sel2, wr2, le2, busy2, done2, err2;
  logic sel3, wr3, le3, busy3, done3, err3;
  logic selp, wrp, lep, busyp, donep, errp;

  int checks = 0;
  int failures = 0;
  int seen;

  always #5 fclk = ~fclk;

  lb_addr_gen #(.LC_BITS(LC), .ADDR_W(AW), .ROW_W(8),
    .NUM_BANKS(2), .EXTRA_LATENCY(5)) u_b2 (
    .fclk(fclk), .reset_n(reset_n), .start(start),
    .layer_code(layer_code), .valid(valid),
    .addr(addr2), .bank(bank2), .sel(sel2), .wr_en(wr2),
    .line_end(le2), .busy(busy2), .done(done2), .err(err2));

  lb_addr_gen #(.LC_BITS(LC), .ADDR_W(AW), .ROW_W(8),
    .NUM_BANKS(3), .EXTRA_LATENCY(5)) u_b3 (
    .fclk(fclk), .reset_n(reset_n), .start(start),
    .layer_code(layer_code), .valid(valid),
    .addr(addr3), .bank(bank3), .sel(sel3), .wr_en(wr3),
    .line_end(le3), .busy(busy3), .done(done3), .err(err3));

  lb_addr_gen #(.LC_BITS(LC), .ADDR_W(AW), .ROW_W(8),
    .NUM_BANKS(2), .EXTRA_LATENCY(0)) u_p (
    .fclk(fclk), .reset_n(reset_n), .start(start),
    .layer_code(layer_code), .valid(valid),
    .addr(addrp), .bank(bankp), .sel(selp), .wr_en(wrp),
    .line_end(lep), .busy(busyp), .done(donep), .err(errp));

  // L sits in [17:8], H in [7:0] with LC_BITS=26
  function automatic logic [LC-1:0] lc(input int l, input int h);
    return LC'((l << 8) | h);
  endfunction

  task automatic tick();
    @(posedge fclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    start   = 1'b0;
    valid   = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    layer_code = '0;
    do_reset();
    chk("rst.wr", wr2, 0);
    chk("rst.addr", addr2, 0);
    chk("rst.bank", bank2, 0);
    chk("rst.busy", busy2, 0);
    chk("rst.done", done2, 0);
    chk("rst.err", err2, 0);

`ifndef LB_ADDR_PAIR_EN
    // valid with no start
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle.wr", wr2, 0);
      chk("idle.busy", busy2, 0);
      chk("idle.le", le2, 0);
    end
    valid = 1'b0;

    // basic frame L=4 H=3, with a start while busy at beat 5
    layer_code = lc(4, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2.busy_on", busy2, 1);
    chk("b2.wr_pre", wr2, 0);
    valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        start = 1'b1;
        layer_code = lc(2, 1);
      end
      tick();
      start = 1'b0;
      chk($sformatf("b2.wr[%0d]", i), wr2, 1);
      chk($sformatf("b2.addr[%0d]", i), addr2, i % 4);
      chk($sformatf("b2.bank[%0d]", i), bank2, (i / 4) % 2);
      chk($sformatf("b2.le[%0d]", i), le2, (i % 4 == 3));
      chk($sformatf("b2.sel[%0d]", i), sel2, 0);
      chk($sformatf("b2.err[%0d]", i), err2, 0);
      chk($sformatf("b2.busy[%0d]", i), busy2, 1);
    end
    valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("b2.done[%0d]", k), done2, (k == 5));
      chk($sformatf("b2.busy_d[%0d]", k), busy2, (k != 5));
      chk($sformatf("b2.wr_d[%0d]", k), wr2, 0);
    end
    tick();
    chk("b2.done_pulse", done2, 0);

    // rejects
    layer_code = lc(0, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej.l0.err", err2, 1);
    chk("rej.l0.busy", busy2, 0);
    tick();
    chk("rej.l0.err_off", err2, 0);
    layer_code = lc(4, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej.h0.err", err2, 1);
    chk("rej.h0.busy", busy2, 0);
    tick();
    chk("rej.h0.err_off", err2, 0);

    // bubbles and 3-bank wrap, L=3 H=4
    do_reset();
    layer_code = lc(3, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      valid = 1'b1;
      tick();
      chk($sformatf("b3.addr[%0d]", i), addr3, i % 3);
      chk($sformatf("b3.bank[%0d]", i), bank3, (i / 3) % 3);
      chk($sformatf("b3.le[%0d]", i), le3, (i % 3 == 2));
      chk($sformatf("b3.wr[%0d]", i), wr3, 1);
      valid = 1'b0;
      tick();
      chk($sformatf("b3.gap[%0d]", i), wr3, 0);
    end
    for (int k = 2; k <= 5; k++) begin
      tick();
      chk($sformatf("b3.done[%0d]", k), done3, (k == 5));
    end
    // start in the done cycle; bank continues from 1, L=1 H=1
    layer_code = lc(1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b3.restart.busy", busy3, 1);
    chk("b3.restart.done", done3, 0);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("b3.l1.wr", wr3, 1);
    chk("b3.l1.addr", addr3, 0);
    chk("b3.l1.bank", bank3, 1);
    chk("b3.l1.le", le3, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("b3.l1.done[%0d]", k), done3, (k == 5));
    end

    // reset mid-frame during line 2
    do_reset();
    layer_code = lc(4, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("mid.pre.bank", bank2, 1);
    chk("mid.pre.addr", addr2, 1);
    reset_n = 1'b0;
    #1;
    chk("mid.wr", wr2, 0);
    chk("mid.addr", addr2, 0);
    chk("mid.bank", bank2, 0);
    chk("mid.busy", busy2, 0);
    chk("mid.le", le2, 0);
    valid = 1'b0;
    tick();
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done2) seen++;
    end
    chk("mid.no_done", seen, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("mid.new.wr", wr2, 1);
    chk("mid.new.addr", addr2, 0);
    chk("mid.new.bank", bank2, 0);

    // zero drain, L=2 H=1
    do_reset();
    layer_code = lc(2, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("d0.addr[%0d]", i), addrp, i);
      chk($sformatf("d0.sel[%0d]", i), selp, 0);
      chk($sformatf("d0.le[%0d]", i), lep, (i == 1));
      chk($sformatf("d0.done[%0d]", i), donep, (i == 1));
      chk($sformatf("d0.busy[%0d]", i), busyp, (i == 0));
    end
    valid = 1'b0;
    tick();
    chk("d0.done_off", donep, 0);
`else
    // pair mode, L=2 H=1, zero drain
    layer_code = lc(2, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("pr.wr[%0d]", i), wrp, 1);
      chk($sformatf("pr.addr[%0d]", i), addrp, i / 2);
      chk($sformatf("pr.sel[%0d]", i), selp, i % 2);
      chk($sformatf("pr.le[%0d]", i), lep, (i == 3));
      chk($sformatf("pr.done[%0d]", i), donep, (i == 3));
      chk($sformatf("pr.bank[%0d]", i), bankp, 0);
    end
    valid = 1'b0;
    tick();
    chk("pr.done_off", donep, 0);
    chk("pr.busy_off", busyp, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
